// File: rtl/mem_dump_streamer_pkg.sv
// mem_dump_streamer_pkg: FSM encoding and shared widths for the memory dump streamer
package mem_dump_streamer_pkg;
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;
    localparam int PASS_W = 16;
endpackage

// File: rtl/mem_dump_streamer_fifo.sv
// mem_dump_streamer_fifo: synchronous first-word-fall-through buffer holding returned read words
module mem_dump_streamer_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_flush,
    input  logic                   i_push,
    input  logic [DATA_W-1:0]      i_data,
    input  logic                   i_pop,
    output logic [DATA_W-1:0]      o_data,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_empty
);
    localparam int AW = $clog2(DEPTH);
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr;
    logic [AW-1:0]     r_rd;
    logic [AW:0]       r_cnt;
    logic              w_push;
    logic              w_pop;
    assign o_empty = r_cnt == '0;
    assign w_pop   = i_pop && !o_empty;
    assign w_push  = i_push && (r_cnt != (AW+1)'(DEPTH) || w_pop);
    assign o_data  = r_mem[r_rd];
    assign o_count = r_cnt;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem <= '{default: '0};
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else if (i_flush) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_mem[r_wr] <= i_data;
            r_wr  <= r_wr + AW'(w_push);
            r_rd  <= r_rd + AW'(w_pop);
            r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end
endmodule

// File: rtl/mem_dump_streamer.sv
// mem_dump_streamer: walks a memory window through a fixed-latency read port and streams
// the returned words over valid/ready, with credit-based issue so the buffer never overflows.
module mem_dump_streamer
    import mem_dump_streamer_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 8,
    parameter int DEPTH      = 16384,
    parameter int LEN_W      = 15,
    parameter int RD_LAT     = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic [ADDR_W-1:0] i_base_addr,
    input  logic [LEN_W-1:0]  i_len,
    input  logic              i_loop,
    output logic [ADDR_W-1:0] o_mem_addr,
    input  logic [DATA_W-1:0] i_mem_data,
    output logic [DATA_W-1:0] o_s_data,
    output logic              o_s_valid,
    input  logic              i_s_ready,
    output logic              o_busy,
    output logic              o_done,
    output logic [PASS_W-1:0] o_pass_cnt
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    state_t            r_state;
    state_t            w_state_nx;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W-1:0] w_base;
    logic [ADDR_W-1:0] w_addr_nx;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_idx;
    logic [LEN_W-1:0]  w_idx;
    logic              r_loop;
    logic [RD_LAT:0]   r_vld;
    logic [PASS_W-1:0] r_pass;
    logic [CW-1:0]     w_count;
    logic              w_empty;
    logic              w_start;
    logic              w_go;
    logic              w_issue;
    logic              w_last;
    logic              w_wrap;
    assign w_base  = i_base_addr % ADDR_W'(DEPTH);
    assign w_start = r_state == S_IDLE && i_start && !i_abort;
    assign w_go    = w_start && i_len != '0;
    // Bit 0 of r_vld is the address phase; the top bit lines up with valid read data.
    assign w_issue = w_go || (r_state == S_RUN && !i_abort && int'(w_count) + $countones(r_vld) < FIFO_DEPTH);
    assign w_idx   = w_start ? '0 : r_idx;
    assign w_last  = w_start ? i_len == LEN_W'(1) : r_idx == r_len - LEN_W'(1);
    assign w_wrap  = w_last && (w_start ? i_loop : r_loop);
    assign w_addr_nx = w_start ? w_base :
                       r_idx == '0 ? r_base :
                       r_addr == ADDR_W'(DEPTH - 1) ? '0 : r_addr + ADDR_W'(1);
    always_comb begin
        w_state_nx = i_abort ? S_IDLE :
                     r_state == S_IDLE ? (w_start ? ((!w_go || (w_last && !w_wrap)) ? S_DRAIN : S_RUN) : S_IDLE) :
                     r_state == S_RUN ? ((w_issue && w_last && !w_wrap) ? S_DRAIN : S_RUN) :
                     r_state == S_DRAIN ? ((w_empty && r_vld == '0) ? S_DONE : S_DRAIN) : S_IDLE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_base  <= '0;
            r_len   <= '0;
            r_idx   <= '0;
            r_loop  <= 1'b0;
            r_vld   <= '0;
            r_pass  <= '0;
        end else begin
            r_state <= w_state_nx;
            r_vld   <= i_abort ? '0 : {r_vld[RD_LAT-1:0], w_issue};
            if (w_start) begin
                r_base <= w_base;
                r_len  <= i_len;
                r_loop <= i_loop;
            end
            if (w_issue) begin
                r_addr <= w_addr_nx;
                r_idx  <= w_last ? '0 : w_idx + LEN_W'(1);
            end
            r_pass <= (w_start ? '0 : r_pass) + PASS_W'(w_issue && w_wrap);
        end
    end
    mem_dump_streamer_fifo #(
        .DATA_W(DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .i_flush(i_abort),
        .i_push (r_vld[RD_LAT]),
        .i_data (i_mem_data),
        .i_pop  (i_s_ready),
        .o_data (o_s_data),
        .o_count(w_count),
        .o_empty(w_empty)
    );
    assign o_mem_addr = r_addr;
    assign o_s_valid  = !w_empty;
    assign o_busy     = r_state == S_RUN || r_state == S_DRAIN;
    assign o_done     = r_state == S_DONE;
    assign o_pass_cnt = r_pass;
endmodule

// File: tb/tb_mem_dump_streamer.sv
// tb_mem_dump_streamer: directed checks of the dump streamer at read latencies 1 and 3
module tb_mem_dump_streamer;
    localparam int DEPTH = 16384;
    logic        clk = 1'b0;
    logic        rst, abort, loop, start_a, start_b, ready_a, ready_b;
    logic [31:0] base;
    logic [14:0] len;
    logic [31:0] a_addr, b_addr;
    logic [7:0]  md_a, a_sdata, b_sdata;
    logic [2:0][7:0] pb;
    logic        a_valid, b_valid, a_busy, b_busy, a_done, b_done;
    logic [15:0] a_pass, b_pass;
    logic [7:0]  mem [DEPTH];
    bit          rand_mode = 1'b0;
    int cyc = 0, checks = 0, errors = 0, ovf = 0;
    int beats_a = 0, beat0_a = 0, err_a = 0, stab_a = 0, done_a = 0, d0_a = 0;
    int beats_b = 0, beat0_b = 0, err_b = 0, stab_b = 0, done_b = 0, d0_b = 0;
    int exp_base_a = 0, exp_len_a = 1, exp_base_b = 0, exp_len_b = 1;
    int k_a, k_b, first_cyc_a, last_cyc_a, lat_a, lat_b, snap;
    bit stall_a = 1'b0, stall_b = 1'b0;
    logic [7:0] hold_a, hold_b;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_dump_streamer #(.RD_LAT(1)) dut_a (
        .clk(clk), .rst(rst), .i_start(start_a), .i_abort(abort), .i_base_addr(base),
        .i_len(len), .i_loop(loop), .o_mem_addr(a_addr), .i_mem_data(md_a),
        .o_s_data(a_sdata), .o_s_valid(a_valid), .i_s_ready(ready_a), .o_busy(a_busy),
        .o_done(a_done), .o_pass_cnt(a_pass)
    );
    mem_dump_streamer #(.RD_LAT(3)) dut_b (
        .clk(clk), .rst(rst), .i_start(start_b), .i_abort(abort), .i_base_addr(base),
        .i_len(len), .i_loop(loop), .o_mem_addr(b_addr), .i_mem_data(pb[2]),
        .o_s_data(b_sdata), .o_s_valid(b_valid), .i_s_ready(ready_b), .o_busy(b_busy),
        .o_done(b_done), .o_pass_cnt(b_pass)
    );

    always @(posedge clk) begin
        md_a <= mem[a_addr[13:0]];
        pb   <= {pb[1:0], mem[b_addr[13:0]]};
    end

    always @(negedge clk) begin
        if (a_valid === 1'b1 && ready_a) begin
            k_a = beats_a - beat0_a;
            if (a_sdata !== mem[(exp_base_a + k_a % exp_len_a) % DEPTH]) err_a++;
            if (k_a == 0) first_cyc_a = cyc;
            last_cyc_a = cyc;
            beats_a++;
        end
        if (stall_a && (a_valid !== 1'b1 || a_sdata !== hold_a)) stab_a++;
        stall_a = a_valid === 1'b1 && !ready_a;
        hold_a  = a_sdata;
        if (a_done === 1'b1) done_a++;
        if (b_valid === 1'b1 && ready_b) begin
            k_b = beats_b - beat0_b;
            if (b_sdata !== mem[(exp_base_b + k_b % exp_len_b) % DEPTH]) err_b++;
            beats_b++;
        end
        if (stall_b && (b_valid !== 1'b1 || b_sdata !== hold_b)) stab_b++;
        stall_b = b_valid === 1'b1 && !ready_b;
        hold_b  = b_sdata;
        if (b_done === 1'b1) done_b++;
        if (dut_a.w_count > 3'd4 || dut_b.w_count > 3'd4) ovf++;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (rand_mode) begin
                ready_a = $urandom_range(0, 9) < 3;
                ready_b = $urandom_range(0, 9) < 3;
            end
        end
    endtask

    task automatic set_pat(input int p);
        for (int i = 0; i < DEPTH; i++) mem[i] = (p == 0) ? 8'(i) : 8'(i ^ (i >> 6));
    endtask

    task automatic go(input bit to_a, input bit to_b, input logic [31:0] b, input int l, input bit lp);
        base = b;
        len  = 15'(l);
        loop = lp;
        if (to_a) begin
            exp_base_a = int'(b % DEPTH); exp_len_a = (l == 0) ? 1 : l; beat0_a = beats_a; d0_a = done_a;
        end
        if (to_b) begin
            exp_base_b = int'(b % DEPTH); exp_len_b = (l == 0) ? 1 : l; beat0_b = beats_b; d0_b = done_b;
        end
        start_a = to_a;
        start_b = to_b;
        tick(1);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic wait_done_a(input string tag, input int budget);
        for (int i = 0; i < budget && done_a == d0_a; i++) tick(1);
        check(tag, done_a - d0_a, 1);
    endtask

    task automatic wait_beats_a(input string tag, input int n, input int budget);
        for (int i = 0; i < budget && beats_a - beat0_a < n; i++) tick(1);
        check(tag, beats_a - beat0_a >= n, 1);
    endtask

    initial begin
        rst = 1'b1; abort = 1'b0; loop = 1'b0; start_a = 1'b0; start_b = 1'b0;
        ready_a = 1'b1; ready_b = 1'b1; base = '0; len = '0;
        set_pat(0);
        tick(3);
        check("rst_addr", a_addr, 0);
        check("rst_valid", a_valid, 0);
        check("rst_data", a_sdata, 0);
        check("rst_busy", a_busy, 0);
        check("rst_done", a_done, 0);
        check("rst_pass", a_pass, 0);
        rst = 1'b0;
        tick(1);

        go(1, 0, 0, 16384, 0);
        check("t1_busy", a_busy, 1);
        wait_done_a("t1_done_seen", 17000);
        tick(3);
        check("t1_beats", beats_a - beat0_a, 16384);
        check("t1_data", err_a, 0);
        check("t1_done_once", done_a - d0_a, 1);
        check("t1_busy_after", a_busy, 0);

        set_pat(1);
        go(1, 0, 16380, 8, 0);
        check("t2_first_addr", a_addr, 16380);
        wait_done_a("t2_done_seen", 100);
        check("t2_beats", beats_a - beat0_a, 8);
        check("t2_data", err_a, 0);
        check("t2_no_gap", last_cyc_a - first_cyc_a, 7);

        go(1, 0, 32'h0001_0003, 3, 0);
        wait_done_a("t2b_done_seen", 100);
        check("t2b_beats", beats_a - beat0_a, 3);
        check("t2b_data", err_a, 0);

        go(1, 0, 500, 0, 0);
        check("t5_done_c1", a_done, 0);
        tick(1);
        check("t5_done_c2", a_done, 1);
        tick(1);
        check("t5_done_c3", a_done, 0);
        check("t5_addr_held", a_addr, 5);
        check("t5_beats", beats_a - beat0_a, 0);

        rand_mode = 1'b1;
        go(1, 1, 100, 300, 0);
        lat_a = 0;
        lat_b = 0;
        for (int k = 1; k <= 12; k++) begin
            tick(1);
            if (a_valid && lat_a == 0) lat_a = k;
            if (b_valid && lat_b == 0) lat_b = k;
        end
        check("t3_lat_a", lat_a, 2);
        check("t3_lat_b", lat_b, 4);
        for (int i = 0; i < 8000 && (done_a == d0_a || done_b == d0_b); i++) tick(1);
        rand_mode = 1'b0;
        ready_a = 1'b1;
        ready_b = 1'b1;
        tick(2);
        check("t3_done_a", done_a - d0_a, 1);
        check("t3_done_b", done_b - d0_b, 1);
        check("t3_beats_a", beats_a - beat0_a, 300);
        check("t3_beats_b", beats_b - beat0_b, 300);
        check("t3_data_a", err_a, 0);
        check("t3_data_b", err_b, 0);
        check("t3_stable_a", stab_a, 0);
        check("t3_stable_b", stab_b, 0);
        check("t3_fifo_ovf", ovf, 0);

        go(1, 0, 7, 5, 1);
        wait_beats_a("t4_beats", 15, 200);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        check("t4_valid_off", a_valid, 0);
        check("t4_busy_off", a_busy, 0);
        check("t4_pass", a_pass, 3);
        tick(4);
        check("t4_no_done", done_a - d0_a, 0);
        check("t4_data", err_a, 0);

        go(1, 0, 0, 50, 1);
        wait_beats_a("t6_beats_pre", 100, 300);
        rst = 1'b1;
        tick(1);
        check("t6_addr", a_addr, 0);
        check("t6_valid", a_valid, 0);
        check("t6_data", a_sdata, 0);
        check("t6_busy", a_busy, 0);
        check("t6_done", a_done, 0);
        check("t6_pass", a_pass, 0);
        tick(1);
        rst = 1'b0;
        snap = beats_a;
        tick(5);
        check("t6_no_beats", beats_a, snap);
        go(1, 0, 40, 20, 0);
        wait_done_a("t6_done_seen", 200);
        check("t6_rerun_beats", beats_a - beat0_a, 20);
        check("t6_rerun_data", err_a, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
